// File: rtl/dm_sba_wb_master.sv
// Bridges the SBA engine's req/gnt/r_valid interface to a single-outstanding
// Wishbone B4 pipelined master, with a watchdog that aborts hung cycles.
module dm_sba_wb_master #(
    parameter int BusWidth      = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   master_req_i,
    input  logic [BusWidth-1:0]                    master_add_i,
    input  logic                                   master_we_i,
    input  logic [BusWidth-1:0]                    master_wdata_i,
    input  logic [BusWidth/8-1:0]                  master_be_i,
    output logic                                   master_gnt_o,
    output logic                                   master_r_valid_o,
    output logic                                   master_r_err_o,
    output logic                                   master_r_other_err_o,
    output logic [BusWidth-1:0]                    master_r_rdata_o,
    output logic                                   wb_cyc_o,
    output logic                                   wb_stb_o,
    output logic                                   wb_we_o,
    output logic [BusWidth-$clog2(BusWidth/8)-1:0] wb_adr_o,
    output logic [BusWidth-1:0]                    wb_dat_o,
    output logic [BusWidth/8-1:0]                  wb_sel_o,
    input  logic                                   wb_stall_i,
    input  logic                                   wb_ack_i,
    input  logic                                   wb_err_i,
    input  logic [BusWidth-1:0]                    wb_dat_i
);

    localparam int BeWidth    = BusWidth / 8;
    localparam int BeIdxWidth = $clog2(BeWidth);
    localparam int WbAdrWidth = BusWidth - BeIdxWidth;
    localparam int CntWidth   = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [WbAdrWidth-1:0]   adr_q, adr_d;
    logic [BusWidth-1:0]     dat_q, dat_d;
    logic [BeWidth-1:0]      sel_q, sel_d;
    logic                    gnt_q, gnt_d, gnt_prev_q;
    logic                    r_valid_q, r_valid_d, r_err_q, r_err_d;
    logic                    r_other_err_q, r_other_err_d;
    logic [BusWidth-1:0]     r_rdata_q, r_rdata_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    quiet_q, quiet_d;
    logic                    term, timeout;
    logic                    unused_add;

    // Byte-offset bits are carried by the byte enables instead.
    assign unused_add = ^master_add_i[BeIdxWidth-1:0];

    assign term    = wb_ack_i | wb_err_i;
    assign timeout = (cnt_q == CntLast);

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        sel_d         = sel_q;
        gnt_d         = 1'b0;
        r_valid_d     = 1'b0;
        r_err_d       = r_err_q;
        r_other_err_d = r_other_err_q;
        r_rdata_d     = r_rdata_q;
        cnt_d         = cnt_q;
        quiet_d       = quiet_q;
        case (state_q)
            IDLE: begin
                if (master_req_i && !gnt_prev_q) begin
                    adr_d         = master_add_i[BusWidth-1:BeIdxWidth];
                    we_d          = master_we_i;
                    dat_d         = master_wdata_i;
                    sel_d         = master_be_i;
                    cyc_d         = 1'b1;
                    stb_d         = 1'b1;
                    cnt_d         = '0;
                    quiet_d       = 1'b0;
                    r_err_d       = 1'b0;
                    r_other_err_d = 1'b0;
                    r_rdata_d     = '0;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CntWidth'(1);
                // A zero-wait termination beats the watchdog; gnt goes out first either way.
                if (!wb_stall_i && term) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    r_err_d   = wb_err_i;
                    r_rdata_d = wb_err_i ? '0 : wb_dat_i;
                    gnt_d     = master_req_i;
                    quiet_d   = !master_req_i;
                    state_d   = RESP;
                end else if (timeout) begin
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    r_other_err_d = 1'b1;
                    gnt_d         = master_req_i;
                    quiet_d       = !master_req_i;
                    state_d       = RESP;
                end else if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    gnt_d   = master_req_i;
                    quiet_d = !master_req_i;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CntWidth'(1);
                if (term) begin
                    cyc_d     = 1'b0;
                    r_err_d   = wb_err_i;
                    r_rdata_d = wb_err_i ? '0 : wb_dat_i;
                    r_valid_d = !quiet_q;
                    state_d   = RESP;
                end else if (timeout) begin
                    cyc_d         = 1'b0;
                    r_other_err_d = 1'b1;
                    r_valid_d     = !quiet_q;
                    state_d       = RESP;
                end
            end
            RESP: begin
                // Entered from ISSUE the gnt cycle comes first, so r_valid follows one cycle later.
                if (r_valid_q || quiet_q) begin
                    state_d = IDLE;
                end else begin
                    r_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            dat_q         <= '0;
            sel_q         <= '0;
            gnt_q         <= 1'b0;
            gnt_prev_q    <= 1'b0;
            r_valid_q     <= 1'b0;
            r_err_q       <= 1'b0;
            r_other_err_q <= 1'b0;
            r_rdata_q     <= '0;
            cnt_q         <= '0;
            quiet_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            sel_q         <= sel_d;
            gnt_q         <= gnt_d;
            gnt_prev_q    <= gnt_q;
            r_valid_q     <= r_valid_d;
            r_err_q       <= r_err_d;
            r_other_err_q <= r_other_err_d;
            r_rdata_q     <= r_rdata_d;
            cnt_q         <= cnt_d;
            quiet_q       <= quiet_d;
        end
    end

    assign master_gnt_o         = gnt_q;
    assign master_r_valid_o     = r_valid_q;
    assign master_r_err_o       = r_err_q;
    assign master_r_other_err_o = r_other_err_q;
    assign master_r_rdata_o     = r_rdata_q;
    assign wb_cyc_o             = cyc_q;
    assign wb_stb_o             = stb_q;
    assign wb_we_o              = we_q;
    assign wb_adr_o             = adr_q;
    assign wb_dat_o             = dat_q;
    assign wb_sel_o             = sel_q;

endmodule

// File: tb/tb_dm_sba_wb_master.sv
// Self-checking bench for dm_sba_wb_master: directed and randomized slave
// behaviours checked against a cycle-count reference model.
module tb_dm_sba_wb_master;

    localparam int BusWidth = 32;
    localparam int Timeout  = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        master_req_i, master_we_i;
    logic [31:0] master_add_i, master_wdata_i;
    logic [3:0]  master_be_i;
    logic        master_gnt_o, master_r_valid_o, master_r_err_o, master_r_other_err_o;
    logic [31:0] master_r_rdata_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i, wb_ack_i, wb_err_i;
    logic [31:0] wb_dat_i;

    int checks   = 0;
    int failures = 0;

    dm_sba_wb_master #(.BusWidth(BusWidth), .TimeoutCycles(Timeout)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .master_req_i(master_req_i), .master_add_i(master_add_i), .master_we_i(master_we_i),
        .master_wdata_i(master_wdata_i), .master_be_i(master_be_i),
        .master_gnt_o(master_gnt_o), .master_r_valid_o(master_r_valid_o),
        .master_r_err_o(master_r_err_o), .master_r_other_err_o(master_r_other_err_o),
        .master_r_rdata_o(master_r_rdata_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_stall_i(wb_stall_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One transaction: kind 0=ack, 1=err, 2=no response. Cycle 0 is the IDLE
    // cycle presenting the request; cyc rises in cycle 1.
    task automatic applyStimulus(input string name, input logic we, input logic [31:0] add,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input int stallCycles, input int respDelay, input int kind,
                                 input int extra, input int hold);
        int a, r, expGnt, expRv, expCyc, expStb, lastCycle;
        bit responds;
        logic [31:0] ackData, expData;
        int gntCount, gntAt, rvCount, rvAt, cycCount, stbCount;
        logic obsErr, obsOther, obsWe;
        logic [31:0] obsData, obsDat;
        logic [29:0] obsAdr;
        logic [3:0] obsSel;

        ackData  = $urandom;
        a        = 1 + stallCycles;
        r        = a + respDelay;
        responds = (kind != 2) && (r <= Timeout);
        if (responds) begin
            expGnt = (respDelay == 0) ? r + 1 : a + 1;
            expRv  = (respDelay == 0) ? r + 2 : r + 1;
        end else if (a < Timeout) begin
            expGnt = a + 1;
            expRv  = Timeout + 1;
        end else begin
            expGnt = Timeout + 1;
            expRv  = Timeout + 2;
        end
        expCyc  = responds ? r : Timeout;
        expStb  = (a < Timeout) ? a : Timeout;
        expData = (responds && kind == 0) ? ackData : 32'h0;

        gntCount = 0; gntAt = -1; rvCount = 0; rvAt = -1; cycCount = 0; stbCount = 0;
        obsErr = 1'bx; obsOther = 1'bx; obsData = 'x;
        obsAdr = 'x; obsWe = 1'bx; obsDat = 'x; obsSel = 'x;
        lastCycle = expRv + extra;

        for (int k = 0; k <= lastCycle; k++) begin
            @(negedge clk_i);
            if (wb_cyc_o) cycCount++;
            if (wb_stb_o) stbCount++;
            if (master_gnt_o) begin gntCount++; gntAt = k; end
            if (master_r_valid_o) begin
                rvCount++; rvAt = k;
                obsErr = master_r_err_o; obsOther = master_r_other_err_o; obsData = master_r_rdata_o;
            end
            if (k == 1) begin
                obsAdr = wb_adr_o; obsWe = wb_we_o; obsDat = wb_dat_o; obsSel = wb_sel_o;
            end
            if (k == 0) begin
                master_req_i = 1'b1; master_we_i = we; master_add_i = add;
                master_wdata_i = wdata; master_be_i = be;
            end else if (gntAt >= 0 && k > gntAt + hold) begin
                master_req_i = 1'b0;
            end
            wb_stall_i = (k >= 1 && k < a);
            wb_ack_i   = (kind == 0 && k == r);
            wb_err_i   = (kind == 1 && k == r);
            wb_dat_i   = (k == r) ? ackData : $urandom;
        end

        checkOutput({name, ".adr"}, obsAdr, add[31:2]);
        checkOutput({name, ".we"}, obsWe, we);
        checkOutput({name, ".dat"}, obsDat, wdata);
        checkOutput({name, ".sel"}, obsSel, be);
        checkOutput({name, ".gntCount"}, gntCount, 1);
        checkOutput({name, ".gntAt"}, gntAt, expGnt);
        checkOutput({name, ".rvCount"}, rvCount, 1);
        checkOutput({name, ".rvAt"}, rvAt, expRv);
        checkOutput({name, ".rErr"}, obsErr, responds && kind == 1);
        checkOutput({name, ".rOtherErr"}, obsOther, !responds);
        checkOutput({name, ".rdata"}, obsData, expData);
        checkOutput({name, ".cycCycles"}, cycCount, expCyc);
        checkOutput({name, ".stbCycles"}, stbCount, expStb);
    endtask

    initial begin
        int cycSeen, rvSeen, gntSeen;
        rst_i = 1'b1;
        master_req_i = 0; master_we_i = 0; master_add_i = 0; master_wdata_i = 0; master_be_i = 0;
        wb_stall_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset.wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o}, 64'h0);
        checkOutput("reset.dat", wb_dat_o, 32'h0);
        checkOutput("reset.master", {master_gnt_o, master_r_valid_o, master_r_err_o, master_r_other_err_o}, 64'h0);
        checkOutput("reset.rdata", master_r_rdata_o, 32'h0);
        rst_i = 1'b0;

        applyStimulus("read", 1'b0, 32'h1000_0004, 32'h0, 4'hF, 0, 2, 0, 1, 0);
        checkOutput("read.adrConst", wb_adr_o, 30'h0400_0001);
        applyStimulus("writeStall", 1'b1, 32'h2000_0008, 32'h0000_AB00, 4'b0010, 3, $urandom_range(1, 3), 0, 1, 1);
        applyStimulus("slaveErr", 1'b0, $urandom, 32'h0, 4'hF, 0, 1, 1, 1, 0);
        applyStimulus("timeoutWait", 1'b0, $urandom, 32'h0, 4'hF, 0, 0, 2, 1, 0);
        applyStimulus("timeoutStall", 1'b0, $urandom, 32'h0, 4'hF, 100, 0, 2, 1, 0);
        applyStimulus("zeroWaitA", 1'b0, $urandom, 32'h0, 4'hF, 0, 0, 0, 0, 1);
        applyStimulus("zeroWaitB", 1'b1, $urandom, $urandom, 4'h3, 1, 0, 0, 0, 0);
        applyStimulus("zeroWaitC", 1'b0, $urandom, 32'h0, 4'hC, 0, 0, 1, 2, 0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus($sformatf("rand%0d", i), 1'($urandom), $urandom, $urandom, 4'($urandom),
                          $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 2),
                          $urandom_range(0, 2), $urandom_range(0, 1));
        end

        // Reset while waiting for the slave, then a stray ack afterwards.
        @(negedge clk_i);
        master_req_i = 1'b1; master_we_i = 1'b0; master_add_i = $urandom; master_be_i = 4'hF;
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        master_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rstWait.cycBefore", wb_cyc_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("rstWait.cycAsync", wb_cyc_o, 1'b0);
        checkOutput("rstWait.stbAsync", wb_stb_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cycSeen = 0; rvSeen = 0; gntSeen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (wb_cyc_o) cycSeen++;
            if (master_r_valid_o) rvSeen++;
            if (master_gnt_o) gntSeen++;
            wb_ack_i = (k == 0);
            wb_dat_i = $urandom;
        end
        checkOutput("rstWait.noRvalid", rvSeen, 0);
        checkOutput("rstWait.noGnt", gntSeen, 0);
        checkOutput("rstWait.noCyc", cycSeen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
